// File: rtl/lights_off_pkg.sv
// Shared definitions for the lights-off game and its solver: FSM states and
// the toggle pattern produced by pressing one switch.
package lights_off_pkg;

    localparam int MAX_N = 64;

    typedef enum logic [2:0] {
        IDLE,
        CHASE,
        CHECK,
        EMIT,
        DONE,
        FAIL
    } state_t;

    // Lights k-1, k, k+1 clipped to [0, n-1]; callers size-cast down to their width.
    function automatic logic [MAX_N-1:0] tmask(input int k, input int n);
        logic [MAX_N-1:0] v;
        v = '0;
        for (int j = 0; j < MAX_N; j++) begin
            if ((j < n) && (j >= k - 1) && (j <= k + 1)) begin
                v[j] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/lights_off_prienc.sv
// Highest-set-bit encoder; o_any flags a non-empty input vector.
module lights_off_prienc #(
    parameter int N  = 10,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_vec,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        // Ascending scan: the last set bit seen is the highest one.
        for (int j = 0; j < N; j++) begin
            if (i_vec[j]) begin
                o_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/lights_off_solver.sv
// Lights-off solver: snapshots a pattern, finds the presses by light chasing
// (second pass forces the top switch), then streams them out descending.
module lights_off_solver
    import lights_off_pkg::*;
#(
    parameter int N  = 10,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  lights,
    output logic          busy,
    output logic          press_valid,
    output logic [IW-1:0] press_idx,
    input  logic          press_ready,
    output logic          done,
    output logic          fail,
    output logic [IW:0]   press_count
);

    localparam logic [IW-1:0] ONE     = IW'(1);
    localparam logic [IW-1:0] TOP_IDX = IW'(N - 1);
    localparam logic [N-1:0]  TOP_BIT = {1'b1, {(N-1){1'b0}}};

    state_t        r_state, w_state_next;
    logic [N-1:0]  r_snap, w_snap_next;
    logic [N-1:0]  r_w, w_w_next;
    logic [N-1:0]  r_m, w_m_next;
    logic          r_pass, w_pass_next;
    logic [IW-1:0] r_i, w_i_next;
    logic [IW:0]   r_press_count, w_press_count_next;

    logic [N-1:0]  w_tm_chase;
    logic [N-1:0]  w_tm_top;
    logic [N-1:0]  w_m_clr;
    logic [IW-1:0] w_hi_idx;
    logic          w_any;

    lights_off_prienc #(
        .N  (N),
        .IW (IW)
    ) u_prienc (
        .i_vec (r_m),
        .o_idx (w_hi_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_tm_chase        = N'(tmask(int'(r_i) - 1, N));
        w_tm_top          = N'(tmask(N - 1, N));
        w_m_clr           = r_m;
        w_m_clr[w_hi_idx] = 1'b0;
    end

    always_comb begin
        w_state_next       = r_state;
        w_snap_next        = r_snap;
        w_w_next           = r_w;
        w_m_next           = r_m;
        w_pass_next        = r_pass;
        w_i_next           = r_i;
        w_press_count_next = r_press_count;
        busy               = (r_state != IDLE);
        press_valid        = 1'b0;
        press_idx          = '0;
        done               = 1'b0;
        fail               = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_snap_next  = lights;
                    w_w_next     = lights;
                    w_m_next     = '0;
                    w_pass_next  = 1'b0;
                    w_i_next     = TOP_IDX;
                    w_state_next = CHASE;
                end
            end
            CHASE: begin
                // A lit light i is cleared by pressing the switch just below it.
                if (r_w[r_i]) begin
                    w_w_next           = r_w ^ w_tm_chase;
                    w_m_next[r_i - ONE] = 1'b1;
                end
                w_i_next = r_i - ONE;
                if (r_i == ONE) begin
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                if (r_w == '0) begin
                    w_press_count_next = (IW+1)'($countones(r_m));
                    w_state_next       = (r_m != '0) ? EMIT : DONE;
                end else if (!r_pass) begin
                    w_pass_next  = 1'b1;
                    w_w_next     = r_snap ^ w_tm_top;
                    w_m_next     = TOP_BIT;
                    w_i_next     = TOP_IDX;
                    w_state_next = CHASE;
                end else begin
                    w_state_next = FAIL;
                end
            end
            EMIT: begin
                press_valid = w_any;
                press_idx   = w_hi_idx;
                if (press_ready && w_any) begin
                    w_m_next = w_m_clr;
                    if (w_m_clr == '0) begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            FAIL: begin
                fail         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_snap        <= '0;
            r_w           <= '0;
            r_m           <= '0;
            r_pass        <= 1'b0;
            r_i           <= '0;
            r_press_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_snap        <= w_snap_next;
            r_w           <= w_w_next;
            r_m           <= w_m_next;
            r_pass        <= w_pass_next;
            r_i           <= w_i_next;
            r_press_count <= w_press_count_next;
        end
    end

    assign press_count = r_press_count;

endmodule

// File: tb/tb_lights_off_solver.sv
// Randomised bench for lights_off_solver (N=10 and N=5 instances) against a
// brute-force reference solver.
module tb_lights_off_solver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start10, press_ready10, busy10, pv10, done10, fail10;
    logic [9:0] lights10;
    logic [3:0] pidx10;
    logic [4:0] pc10;

    logic       start5, press_ready5, busy5, pv5, done5, fail5;
    logic [4:0] lights5;
    logic [2:0] pidx5;
    logic [3:0] pc5;

    int n_checks = 0;
    int n_errors = 0;

    lights_off_solver #(.N(10)) dut10 (
        .clk         (clk),
        .rst         (rst),
        .start       (start10),
        .lights      (lights10),
        .busy        (busy10),
        .press_valid (pv10),
        .press_idx   (pidx10),
        .press_ready (press_ready10),
        .done        (done10),
        .fail        (fail10),
        .press_count (pc10)
    );

    lights_off_solver #(.N(5)) dut5 (
        .clk         (clk),
        .rst         (rst),
        .start       (start5),
        .lights      (lights5),
        .busy        (busy5),
        .press_valid (pv5),
        .press_idx   (pidx5),
        .press_ready (press_ready5),
        .done        (done5),
        .fail        (fail5),
        .press_count (pc5)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Lights toggled by pressing every switch in 'mask'.
    function automatic int effect(input int mask, input int n);
        int v;
        v = 0;
        for (int k = 0; k < n; k++) begin
            if (((mask >> k) & 1) == 1) begin
                for (int j = k - 1; j <= k + 1; j++) begin
                    if (j >= 0 && j < n) v = v ^ (1 << j);
                end
            end
        end
        return v;
    endfunction

    // Smallest press set clearing 'pat' (top switch unpressed preferred), or -1.
    function automatic int model_solve(input int pat, input int n);
        for (int s = 0; s < (1 << n); s++) begin
            if (effect(s, n) == pat) return s;
        end
        return -1;
    endfunction

    task automatic run(input bit sel, input int pat, input bit rnd_ready, input bit start_noise);
        int n, sol, exp_cnt, search_end, c, done_c, fail_c, first_v, last_hs, prev_idx, eff;
        int v_idx, v_pc, pc_seen;
        bit v_busy, v_valid, v_done, v_fail, rdy, stall, busy_bad, valid_bad;
        int idxq[$];
        int expq[$];
        n   = sel ? 5 : 10;
        sol = model_solve(pat, n);
        exp_cnt = 0;
        if (sol >= 0) begin
            for (int k = n - 1; k >= 0; k--) begin
                if (((sol >> k) & 1) == 1) begin
                    expq.push_back(k);
                    exp_cnt++;
                end
            end
        end
        search_end = (sol >= 0 && ((sol >> (n - 1)) & 1) == 0) ? n : 2 * n;

        @(negedge clk);
        if (sel) begin lights5 = pat[4:0]; start5 = 1'b1; end
        else begin lights10 = pat[9:0]; start10 = 1'b1; end
        @(negedge clk);
        start5 = 1'b0; start10 = 1'b0;
        lights5 = 5'($urandom); lights10 = 10'($urandom);

        c = 1; done_c = -1; fail_c = -1; first_v = -1; last_hs = -1;
        stall = 0; busy_bad = 0; valid_bad = 0; prev_idx = 0; pc_seen = -1;
        while (done_c < 0 && fail_c < 0 && c < 100) begin
            v_busy  = sel ? busy5 : busy10;
            v_valid = sel ? pv5 : pv10;
            v_done  = sel ? done5 : done10;
            v_fail  = sel ? fail5 : fail10;
            v_idx   = sel ? int'(pidx5) : int'(pidx10);
            v_pc    = sel ? int'(pc5) : int'(pc10);
            if (!v_busy) busy_bad = 1;
            if (v_done) begin done_c = c; pc_seen = v_pc; end
            if (v_fail) fail_c = c;
            if ((v_done || v_fail) && v_valid) valid_bad = 1;
            if (start_noise && !(v_done || v_fail)) begin
                start5 = sel ? 1'($urandom) : 1'b0;
                start10 = sel ? 1'b0 : 1'($urandom);
            end else begin
                start5 = 1'b0; start10 = 1'b0;
            end
            if (v_valid) begin
                if (first_v < 0) first_v = c;
                if (stall) chk("idx_stable", v_idx, prev_idx);
                rdy = rnd_ready ? 1'($urandom) : 1'b1;
                if (rdy) begin idxq.push_back(v_idx); last_hs = c; end
                stall = !rdy;
                prev_idx = v_idx;
            end else begin
                if (stall) chk("valid_held", 0, 1);
                rdy = 1'($urandom);
                stall = 0;
            end
            if (sel) press_ready5 = rdy; else press_ready10 = rdy;
            @(negedge clk);
            c++;
        end
        press_ready5 = 1'b0; press_ready10 = 1'b0; start5 = 1'b0; start10 = 1'b0;

        chk("busy_whole_run", busy_bad, 0);
        chk("valid_in_done_fail", valid_bad, 0);
        if (sol < 0) begin
            chk("fail_cycle", fail_c, 2 * n + 1);
            chk("no_done", done_c, -1);
            chk("no_presses", idxq.size(), 0);
        end else begin
            chk("no_fail", fail_c, -1);
            chk("done_cycle", done_c, (exp_cnt == 0) ? search_end + 1 : last_hs + 1);
            chk("first_valid", first_v, (exp_cnt == 0) ? -1 : search_end + 1);
            chk("press_count", pc_seen, exp_cnt);
            chk("num_presses", idxq.size(), exp_cnt);
            for (int k = 0; k < idxq.size() && k < expq.size(); k++) begin
                chk("press_idx", idxq[k], expq[k]);
            end
            eff = 0;
            foreach (idxq[k]) eff = eff ^ effect(1 << idxq[k], n);
            chk("presses_clear", eff, pat);
            chk("count_held", sel ? int'(pc5) : int'(pc10), exp_cnt);
        end
        chk("idle_not_busy", sel ? busy5 : busy10, 0);
        $display("txn N=%0d lights=0x%0h presses=%0d done@%0d fail@%0d", n, pat, idxq.size(), done_c, fail_c);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat, sol;
        rst = 1'b1;
        start10 = 1'b0; press_ready10 = 1'b0; lights10 = '0;
        start5 = 1'b0; press_ready5 = 1'b0; lights5 = '0;
        #1;
        chk("rst_busy", busy10, 0);
        chk("rst_valid", pv10, 0);
        chk("rst_idx", pidx10, 0);
        chk("rst_done", done10, 0);
        chk("rst_fail", fail10, 0);
        chk("rst_count", pc10, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run(1'b0, 32'h000, 1'b0, 1'b0);
        run(1'b0, 32'h003, 1'b0, 1'b0);
        run(1'b0, 32'h300, 1'b0, 1'b0);
        for (int t = 0; t < 8; t++) begin
            run(1'b0, int'($urandom_range(1023, 0)), 1'b1, 1'($urandom));
        end

        run(1'b1, 32'h01, 1'b0, 1'b0);
        run(1'b1, 32'h01, 1'b0, 1'b1);
        for (int t = 0; t < 5; t++) begin
            run(1'b1, int'($urandom_range(31, 0)), 1'b1, 1'b1);
        end

        // Abort mid-emit with at least two presses still pending.
        pat = 3;
        for (int t = 0; t < 1000; t++) begin
            pat = int'($urandom_range(1023, 0));
            sol = model_solve(pat, 10);
            if ($countones(sol) >= 2) break;
        end
        @(negedge clk);
        lights10 = pat[9:0]; start10 = 1'b1;
        @(negedge clk);
        start10 = 1'b0; press_ready10 = 1'b0;
        for (int t = 0; t < 50 && !pv10; t++) @(negedge clk);
        chk("rst_reach_emit", pv10, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_busy", busy10, 0);
        chk("async_valid", pv10, 0);
        chk("async_idx", pidx10, 0);
        chk("async_done", done10, 0);
        chk("async_fail", fail10, 0);
        chk("async_count", pc10, 0);
        $display("txn N=10 async reset during emit lights=0x%0h", pat);
        @(negedge clk);
        rst = 1'b0;
        run(1'b0, int'($urandom_range(1023, 0)), 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
